// File: rtl/snn_phase_sequencer_if.sv
// Control/status bundle between the layer controller (master) and the
// SNN phase sequencer (slave).
interface snn_phase_sequencer_if #(
   parameter int CNT_W  = 8,
   parameter int STEP_W = 4
);
   logic              start;
   logic              abort;
   logic              stall;
   logic [CNT_W-1:0]  cfg_load_len;
   logic [CNT_W-1:0]  cfg_int_len;
   logic [STEP_W-1:0] cfg_steps;
   logic [2:0]        state;
   logic [2:0]        state_next;
   logic              busy;
   logic              fire;
   logic              done;
   logic [STEP_W-1:0] step_idx;
   logic [CNT_W-1:0]  phase_cnt;

   modport master (
      output start, abort, stall, cfg_load_len, cfg_int_len, cfg_steps,
      input  state, state_next, busy, fire, done, step_idx, phase_cnt
   );

   modport slave (
      input  start, abort, stall, cfg_load_len, cfg_int_len, cfg_steps,
      output state, state_next, busy, fire, done, step_idx, phase_cnt
   );
endinterface

// File: rtl/snn_phase_sequencer.sv
// Multi-timestep LOAD -> INTEG -> FIRE sequencer with stall/abort and a DONE pulse.
// Optional macro SEQ_AUTO_RESTART_EN: start in DONE launches the next run directly.
module snn_phase_sequencer #(
   parameter int CNT_W  = 8,
   parameter int STEP_W = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   snn_phase_sequencer_if.slave  bus
);
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_INTEG = 3'd2,
      S_FIRE  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  phase_q, phase_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [CNT_W-1:0]  load_sh, int_sh;
   logic [STEP_W-1:0] steps_sh;
   logic              cap;
   logic [CNT_W-1:0]  load_last, int_last;
   logic [STEP_W-1:0] step_last;

   // Zero-length phases behave as one cycle, so the terminal index saturates at 0.
   assign load_last = (load_sh == '0) ? '0 : load_sh - CNT_ONE;
   assign int_last  = (int_sh  == '0) ? '0 : int_sh  - CNT_ONE;
   assign step_last = steps_sh - STEP_ONE;

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      step_d  = step_q;
      cap     = 1'b0;
      if (bus.abort) begin
         state_d = S_IDLE;
         phase_d = '0;
         step_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               phase_d = '0;
               step_d  = '0;
               if (bus.start) begin
                  cap     = 1'b1;
                  state_d = (bus.cfg_steps == '0) ? S_DONE : S_LOAD;
               end
            end
            S_LOAD: begin
               if (!bus.stall) begin
                  if (phase_q == load_last) begin
                     state_d = S_INTEG;
                     phase_d = '0;
                  end else begin
                     phase_d = phase_q + CNT_ONE;
                  end
               end
            end
            S_INTEG: begin
               if (!bus.stall) begin
                  if (phase_q == int_last) begin
                     state_d = S_FIRE;
                     phase_d = '0;
                  end else begin
                     phase_d = phase_q + CNT_ONE;
                  end
               end
            end
            S_FIRE: begin
               if (!bus.stall) begin
                  phase_d = '0;
                  if (step_q == step_last) begin
                     state_d = S_DONE;
                  end else begin
                     step_d  = step_q + STEP_ONE;
                     state_d = S_LOAD;
                  end
               end
            end
            S_DONE: begin
               phase_d = '0;
               step_d  = '0;
               state_d = S_IDLE;
`ifdef SEQ_AUTO_RESTART_EN
               if (bus.start) begin
                  cap     = 1'b1;
                  state_d = (bus.cfg_steps == '0) ? S_DONE : S_LOAD;
               end
`endif
            end
            default: begin
               state_d = S_IDLE;
               phase_d = '0;
               step_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         phase_q  <= '0;
         step_q   <= '0;
         load_sh  <= '0;
         int_sh   <= '0;
         steps_sh <= '0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         step_q  <= step_d;
         if (cap) begin
            load_sh  <= bus.cfg_load_len;
            int_sh   <= bus.cfg_int_len;
            steps_sh <= bus.cfg_steps;
         end
      end
   end

   assign bus.state      = state_q;
   assign bus.state_next = state_d;
   assign bus.busy       = (state_q != S_IDLE);
   assign bus.fire       = (state_q == S_FIRE);
   assign bus.done       = (state_q == S_DONE);
   assign bus.step_idx   = step_q;
   assign bus.phase_cnt  = phase_q;
endmodule

// File: tb/tb_snn_phase_sequencer.sv
// Scoreboard bench for snn_phase_sequencer: stimulus pushes an expected per-cycle
// trace, a negedge monitor pops and compares it against the DUT outputs.
module tb_snn_phase_sequencer;
   localparam int CNT_W  = 8;
   localparam int STEP_W = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   snn_phase_sequencer_if #(.CNT_W(CNT_W), .STEP_W(STEP_W)) bus ();
   snn_phase_sequencer #(.CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [2:0]        st;
      logic [STEP_W-1:0] step;
      logic [CNT_W-1:0]  ph;
   } obs_t;

   obs_t exp_q[$];
   obs_t last_exp;
   int   total = 0;
   int   bad   = 0;
   bit   checking = 1'b0;
   logic stall_s = 1'b0, abort_s = 1'b0, rst_s = 1'b0;

   function automatic obs_t mk(int st, int step, int ph);
      obs_t o;
      o.st   = 3'(st);
      o.step = STEP_W'(step);
      o.ph   = CNT_W'(ph);
      return o;
   endfunction

   // Expected trace of one run straight from the phase rules; returns its cycle count.
   function automatic int push_run(int l, int i, int steps);
      int le = (l == 0) ? 1 : l;
      int ie = (i == 0) ? 1 : i;
      if (steps == 0) begin
         exp_q.push_back(mk(4, 0, 0));
         return 1;
      end
      for (int s = 0; s < steps; s++) begin
         for (int p = 0; p < le; p++) exp_q.push_back(mk(1, s, p));
         for (int p = 0; p < ie; p++) exp_q.push_back(mk(2, s, p));
         exp_q.push_back(mk(3, s, 0));
      end
      exp_q.push_back(mk(4, steps - 1, 0));
      return steps * (le + ie + 1) + 1;
   endfunction

   always @(posedge clk) begin
      stall_s <= bus.stall;
      abort_s <= bus.abort;
      rst_s   <= rst;
   end

   initial last_exp = '0;

   always @(negedge clk) begin
      if (checking) begin
         obs_t e;
         if (rst_s || abort_s) begin
            exp_q.delete();
            e = mk(0, 0, 0);
         end else if (stall_s && (last_exp.st inside {3'd1, 3'd2, 3'd3})) begin
            e = last_exp;
         end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
         end else begin
            e = mk(0, 0, 0);
         end
         last_exp = e;
         total++;
         if ({bus.state, bus.step_idx, bus.phase_cnt, bus.busy, bus.fire, bus.done} !==
             {e.st, e.step, e.ph, (e.st != 3'd0), (e.st == 3'd3), (e.st == 3'd4)}) begin
            bad++;
            $display("FAIL trace t=%0t got st=%0d step=%0d ph=%0d busy=%b fire=%b done=%b want st=%0d step=%0d ph=%0d",
                     $time, bus.state, bus.step_idx, bus.phase_cnt, bus.busy, bus.fire, bus.done,
                     e.st, e.step, e.ph);
         end
      end
   end

   task automatic check_drained(string name);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL %s left=%0d want=0", name, exp_q.size());
      end
   endtask

   // mode 0: no stall, 1: fixed stall window, 2: random stall every cycle
   task automatic run(int l, int i, int steps, int mode, int st_at, int st_len, bit chk_done);
      int n, cnt;
      bit seen;
      bus.cfg_load_len = CNT_W'(l);
      bus.cfg_int_len  = CNT_W'(i);
      bus.cfg_steps    = STEP_W'(steps);
      bus.start        = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      n = push_run(l, i, steps);
      bus.cfg_load_len = CNT_W'($urandom);
      bus.cfg_int_len  = CNT_W'($urandom);
      bus.cfg_steps    = STEP_W'($urandom);
      cnt  = 0;
      seen = 1'b0;
      fork
         begin
            if (mode == 1) begin
               repeat (st_at) @(posedge clk);
               #1 bus.stall = 1'b1;
               repeat (st_len) @(posedge clk);
               #1 bus.stall = 1'b0;
            end else if (mode == 2) begin
               for (int g = 0; g < 4000 && exp_q.size() > 0; g++) begin
                  @(posedge clk);
                  #1 bus.stall = ($urandom_range(0, 3) == 0);
               end
               bus.stall = 1'b0;
            end
         end
         begin
            for (int g = 0; g < 4000 && !seen; g++) begin
               @(negedge clk);
               cnt++;
               if (bus.done) seen = 1'b1;
            end
         end
      join
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL done_timeout cycles=%0d want done within bound", cnt);
      end else if (chk_done && cnt != n + st_len) begin
         bad++;
         $display("FAIL done_latency got=%0d want=%0d", cnt, n + st_len);
      end
      repeat (2) @(posedge clk);
      #1;
      check_drained("run_drain");
   endtask

   task automatic abort_test();
      bus.cfg_load_len = 8'd2;
      bus.cfg_int_len  = 8'd3;
      bus.cfg_steps    = 4'd2;
      bus.start        = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      void'(push_run(2, 3, 2));
      repeat (6) @(posedge clk);
      #1 bus.abort = 1'b1;
      bus.stall = 1'b1;
      @(posedge clk);
      #1 bus.abort = 1'b0;
      bus.stall = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_drained("abort_drain");
   endtask

   task automatic reset_test();
      bus.cfg_load_len = 8'd2;
      bus.cfg_int_len  = 8'd3;
      bus.cfg_steps    = 4'd2;
      bus.start        = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      void'(push_run(2, 3, 2));
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      bus.start = 1'b1;
      bus.stall = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      bus.start = 1'b0;
      bus.stall = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_drained("reset_drain");
   endtask

   task automatic b2b_test();
      int n1;
      bus.cfg_load_len = 8'd2;
      bus.cfg_int_len  = 8'd1;
      bus.cfg_steps    = 4'd1;
      bus.start        = 1'b1;
      @(posedge clk);
      #1;
      n1 = push_run(2, 1, 1);
`ifndef SEQ_AUTO_RESTART_EN
      exp_q.push_back(mk(0, 0, 0));
      n1 = n1 + 1;
`endif
      void'(push_run(1, 2, 2));
      bus.cfg_load_len = 8'd1;
      bus.cfg_int_len  = 8'd2;
      bus.cfg_steps    = 4'd2;
      repeat (n1) @(posedge clk);
      #1 bus.start = 1'b0;
      for (int g = 0; g < 200 && exp_q.size() > 0; g++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
      check_drained("b2b_drain");
   endtask

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.stall = 1'b0;
      bus.cfg_load_len = '0;
      bus.cfg_int_len  = '0;
      bus.cfg_steps    = '0;
      rst = 1'b1;
      @(posedge clk);
      #1 checking = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      run(2, 3, 2, 0, 0, 0, 1'b1);
      run(0, 0, 3, 0, 0, 0, 1'b1);
      run(0, 0, 0, 0, 0, 0, 1'b1);
      run(2, 3, 2, 1, 2, 4, 1'b1);
      abort_test();
      reset_test();
      b2b_test();
      for (int k = 0; k < 10; k++)
         run($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 5), 0, 0, 0, 1'b1);
      for (int k = 0; k < 20; k++)
         run($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4), 2, 0, 0, 1'b0);
      checking = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
